tinyqv_mem_sequencer: RTL
=========================

# tinyqv_mem_sequencer

Sequences one decoded load or store into 1–8 back-to-back memory transactions, using the decoder's `additional_mem_ops` and `mem_op_increment_reg` fields. It sits between the decode stage and the memory interface. For each transaction it steps the address by the access size and, optionally, steps the data register index. It drives register-file write enables for load responses and supports a flush that abandons the sequence cleanly.

## Interface
Parameters:
- `ADDR_W`, default 28: byte address width; address arithmetic wraps modulo 2^ADDR_W.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous and active-high.
- `instr_valid` in 1: decoded instruction present.
- `instr_ready` out 1: sequencer can accept an instruction; high only in IDLE.
- `is_load` in 1: decoded load.
- `is_store` in 1: decoded store.
- `mem_op` in 3: RISC-V funct3. [1:0] is the size (0 = byte, 1 = half, 2 = word); [2] is unsigned.
- `base_addr` in ADDR_W: computed rs1 + imm.
- `data_reg` in 4: rd for loads, rs2 for stores.
- `additional_mem_ops` in 3: number of extra transactions (0–7).
- `mem_op_increment_reg` in 1: step the register index by 1 per transaction.
- `flush` in 1: abandon the current sequence.
- `mem_req_valid` out 1: request to memory.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_addr` out ADDR_W: request address.
- `mem_op_out` out 3: latched `mem_op`.
- `mem_is_store` out 1: request is a store.
- `mem_reg` out 4: register index for this transaction. Stores use it as the RF read index.
- `mem_rsp_valid` in 1: load data returned (exactly one cycle per accepted load).
- `rf_we` out 1: register-file write strobe for load data.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse when a sequence completes normally.

## Operation
States: IDLE, ISSUE, WAIT_RSP, DRAIN.

- **IDLE**
  - On `instr_valid` with (`is_load` | `is_store`): latch `base_addr`, `mem_op`, `data_reg`, the store flag and the increment flag. Set remaining = `additional_mem_ops`, then go to ISSUE.
  - An instruction with neither flag is accepted and ignored: no `done`, no state change.
  - If `is_load` and `is_store` are both set, `is_load` takes precedence.
- **ISSUE**
  - `mem_req_valid` = 1. Address, op and reg are held stable until `mem_req_ready`.
  - Store accepted with remaining = 0: go to IDLE and pulse `done` on the next cycle.
  - Store accepted with remaining > 0: advance, stay in ISSUE.
  - Load accepted: go to WAIT_RSP.
- **WAIT_RSP**
  - On `mem_rsp_valid`: `rf_we` = 1 (combinational) unless `mem_reg` = 0; x0 writes are suppressed.
  - Then, if remaining = 0, go to IDLE and pulse `done`; otherwise advance and go to ISSUE.
- **Advance**
  - addr += 1 << size. Size 3 is treated as 4 bytes.
  - reg += `mem_op_increment_reg` (4-bit wrap: 15 → 0).
  - remaining -= 1.
- **Flush** (highest priority):
  - ISSUE: go to IDLE; request dropped next cycle even if `mem_req_ready` was high in the same cycle; no `done`.
  - WAIT_RSP without `mem_rsp_valid`: go to DRAIN.
  - WAIT_RSP with `mem_rsp_valid` in the same cycle: `rf_we` = 0, go to IDLE.
- **DRAIN**
  - Waits for `mem_rsp_valid` with `rf_we` = 0, then goes to IDLE.
  - `flush` is ignored in DRAIN.
- Misalignment is not checked. The address wraps at 2^ADDR_W.

## Timing
- Reset: state = IDLE and all registers zero.
  - `instr_ready` = 1; `mem_req_valid`, `rf_we`, `busy` and `done` = 0.
  - `mem_addr` = 0, `mem_reg` = 0, `mem_op_out` = 0.
- Accept at edge N → `mem_req_valid` high from cycle N+1.
- Zero-wait store sequence of k transactions: requests in cycles N+1..N+k, `done` in N+k+1, `instr_ready` high in N+k+1.
- Load transaction with the response in the cycle after acceptance: 2 cycles per transaction.
- `done` and `busy` are registered. `done` coincides with the first IDLE cycle.
- `rf_we`, `mem_req_valid` and `instr_ready` are decoded from registered state, except `rf_we`, which also depends on the current `mem_rsp_valid` and `flush`.
- An asynchronous `rst` mid-sequence returns the block to IDLE immediately. Any outstanding memory response is the memory side's responsibility.

## Structure
- Shared package `tinyqv_pkg` holds:
  - the state enum, and
  - constants for the mem_op size encodings (MEM_SIZE_B/H/W).
- Sub-module `tinyqv_mem_step`: combinational next address and next reg from (addr, reg, size, increment flag).
- Everything else lives in a single always block plus output decode.

## Test plan
- Single word store: `base_addr` 0x100, additional 0 → one request at 0x100, `done` 2 cycles after accept.
- Multi-store: `additional_mem_ops` 3, word, increment=1, `data_reg` 8, base 0x200, ready stalled 2 cycles on the second request → addr/reg 0x200/8, 0x204/9, 0x208/10, 0x20C/11; request held stable while stalled.
- Multi-load: byte, additional 2, increment=0, `data_reg` 0, base 0xFFFFFFF → addresses 0xFFFFFFF, 0x0000000, 0x0000001; `rf_we` never asserts.
- Reg wrap: half, additional 1, `data_reg` 15, increment=1 → `mem_reg` 15 then 0; addresses +2.
- Flush: flush in ISSUE → IDLE with no `done`; flush in WAIT_RSP → DRAIN, response 3 cycles later gives no `rf_we`, then IDLE; flush with `mem_rsp_valid` in the same cycle → `rf_we` 0, IDLE next cycle.
- Reset asserted during WAIT_RSP → all outputs at reset values immediately; `instr_ready` = 1.

Source files
------------

// File: rtl/tinyqv_pkg.sv
// Shared types and constants for the TinyQV load/store sequencing logic.
// Holds the sequencer state encoding and the funct3 access-size codes.
package tinyqv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  // log2 of the access size in bytes; the unused code 3 behaves like a word
  function automatic logic [1:0] size_log2(input logic [1:0] size);
    logic [1:0] res;
    case (size)
      MEM_SIZE_B: res = 2'd0;
      MEM_SIZE_H: res = 2'd1;
      default:    res = 2'd2;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tinyqv_mem_step.sv
// Next-transaction address and register index for a multi-op load/store.
// Address wraps at 2^ADDR_W, register index wraps at 16.
module tinyqv_mem_step
  import tinyqv_pkg::*;
#(
  parameter int ADDR_W = 28
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        reg_idx,
  input  logic [1:0]        size,
  input  logic              inc,
  output logic [ADDR_W-1:0] next_addr,
  output logic [3:0]        next_reg
);

  logic [ADDR_W-1:0] stride;

  assign stride    = {{(ADDR_W-1){1'b0}}, 1'b1} << size_log2(size);
  assign next_addr = addr + stride;
  assign next_reg  = reg_idx + {3'b000, inc};

endmodule

// File: rtl/tinyqv_mem_sequencer.sv
// Expands one decoded load/store into 1-8 back-to-back memory transactions,
// stepping address and optionally register index, with a clean flush path.
module tinyqv_mem_sequencer
  import tinyqv_pkg::*;
#(
  parameter int ADDR_W = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        data_reg,
  input  logic [2:0]        additional_mem_ops,
  input  logic              mem_op_increment_reg,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_op_out,
  output logic              mem_is_store,
  output logic [3:0]        mem_reg,
  input  logic              mem_rsp_valid,
  output logic              rf_we,
  output logic              busy,
  output logic              done
);

  // Request handshake: a transaction transfers on a cycle where mem_req_valid
  // and mem_req_ready are both high; address/op/reg stay stable until then.

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        op;
  logic [3:0]        reg_idx;
  logic              store;
  logic              inc;
  logic [2:0]        remaining;
  logic              done_q;

  logic [ADDR_W-1:0] next_addr;
  logic [3:0]        next_reg;

  tinyqv_mem_step #(.ADDR_W(ADDR_W)) u_step (
    .addr      (addr),
    .reg_idx   (reg_idx),
    .size      (op[1:0]),
    .inc       (inc),
    .next_addr (next_addr),
    .next_reg  (next_reg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      op        <= '0;
      reg_idx   <= '0;
      store     <= 1'b0;
      inc       <= 1'b0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid && (is_load || is_store)) begin
            addr      <= base_addr;
            op        <= mem_op;
            reg_idx   <= data_reg;
            store     <= ~is_load;
            inc       <= mem_op_increment_reg;
            remaining <= additional_mem_ops;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // flush wins even over a request accepted in the same cycle
          if (flush) begin
            state <= ST_IDLE;
          end else if (mem_req_ready) begin
            if (!store) begin
              state <= ST_WAIT_RSP;
            end else if (remaining == 3'd0) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else begin
              addr      <= next_addr;
              reg_idx   <= next_reg;
              remaining <= remaining - 3'd1;
            end
          end
        end
        ST_WAIT_RSP: begin
          if (mem_rsp_valid) begin
            if (flush) begin
              state <= ST_IDLE;
            end else if (remaining == 3'd0) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else begin
              addr      <= next_addr;
              reg_idx   <= next_reg;
              remaining <= remaining - 3'd1;
              state     <= ST_ISSUE;
            end
          end else if (flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mem_rsp_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready   = (state == ST_IDLE);
  assign mem_req_valid = (state == ST_ISSUE);
  assign busy          = (state != ST_IDLE);
  assign done          = done_q;
  assign mem_addr      = addr;
  assign mem_op_out    = op;
  assign mem_is_store  = store;
  assign mem_reg       = reg_idx;
  // x0 is never written; a flushed or drained response is discarded
  assign rf_we = (state == ST_WAIT_RSP) && mem_rsp_valid && !flush && (reg_idx != 4'd0);

endmodule
